// File: rtl/nes_timer_pkg.sv
// Shared timer register map, control/status bit positions and sequencer states.
// Purely declarative; no latency or flow-control behaviour of its own.
package nes_timer_pkg;

    localparam logic [2:0] TMR_ADDR_STATUS   = 3'd0;
    localparam logic [2:0] TMR_ADDR_CONTROL  = 3'd1;
    localparam logic [2:0] TMR_ADDR_PERIOD_L = 3'd2;
    localparam logic [2:0] TMR_ADDR_PERIOD_H = 3'd3;
    localparam logic [2:0] TMR_ADDR_SNAP_L   = 3'd4;
    localparam logic [2:0] TMR_ADDR_SNAP_H   = 3'd5;

    localparam int CTRL_ITO   = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_START = 2;
    localparam int CTRL_STOP  = 3;

    localparam int STAT_TO  = 0;
    localparam int STAT_RUN = 1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_PL,
        ST_WR_PH,
        ST_WR_CTRL,
        ST_RUN,
        ST_CLR,
        ST_STOP,
        ST_POLL_RD,
        ST_POLL_CHK
    } tmr_state_t;

    function automatic logic [15:0] ctrl_word(input logic ito, input logic cont,
                                              input logic start, input logic stop);
        logic [15:0] w;
        w             = '0;
        w[CTRL_ITO]   = ito;
        w[CTRL_CONT]  = cont;
        w[CTRL_START] = start;
        w[CTRL_STOP]  = stop;
        return w;
    endfunction

endpackage

// File: rtl/nes_timer_sequencer_if.sv
// Avalon-MM link between the sequencer (master) and the interval timer s1 port (slave).
// Slave has no waitrequest; read data returns one cycle after the address.
interface nes_timer_sequencer_if;
    logic [2:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [15:0] avm_writedata;
    logic [15:0] avm_readdata;
    logic        timer_irq;

    modport master (
        output avm_address, avm_chipselect, avm_write_n, avm_writedata,
        input  avm_readdata, timer_irq
    );

    modport slave (
        input  avm_address, avm_chipselect, avm_write_n, avm_writedata,
        output avm_readdata, timer_irq
    );
endinterface

// File: rtl/nes_timer_sequencer_avm_write_port.sv
// Registers one Avalon access per cycle onto the bus; request to bus is 1 cycle.
// No backpressure: the slave accepts every access in the cycle it is driven.
module nes_avm_write_port (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_vld,
    input  logic        req_wr,
    input  logic [2:0]  req_addr,
    input  logic [15:0] req_dat,
    output logic [2:0]  avm_address,
    output logic        avm_chipselect,
    output logic        avm_write_n,
    output logic [15:0] avm_writedata
);
    always_ff @(posedge clk) begin
        if (reset) begin
            avm_address    <= '0;
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            avm_writedata  <= '0;
        end else begin
            avm_chipselect <= req_vld;
            avm_write_n    <= !(req_vld && req_wr);
            avm_address    <= req_vld ? req_addr : 3'd0;
            avm_writedata  <= (req_vld && req_wr) ? req_dat : 16'd0;
        end
    end
endmodule

// File: rtl/nes_timer_sequencer.sv
// Drives the interval timer over Avalon-MM and emits one frame_tick per serviced timeout;
// accesses appear one cycle after the deciding edge. TIMER_POLL_EN selects status polling.
module nes_timer_sequencer
    import nes_timer_pkg::*;
#(
    parameter logic [31:0] DEFAULT_PERIOD = 32'd833332,
    parameter int          CTRL_W         = 4,
    parameter logic [15:0] TICK_PRESET    = 16'h0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [31:0]           period_in,
    input  logic                  period_load,
    nes_timer_sequencer_if.master avm,
    output logic                  frame_tick,
    output logic [15:0]           tick_count,
    output logic                  running,
    output logic                  busy
);
`ifdef TIMER_POLL_EN
    localparam logic ITO_EN = 1'b0;
`else
    localparam logic ITO_EN = 1'b1;
`endif
    localparam logic [15:0] CTRL_MASK = 16'((32'd1 << CTRL_W) - 32'd1);
    localparam logic [15:0] CTRL_GO   = ctrl_word(ITO_EN, 1'b1, 1'b1, 1'b0) & CTRL_MASK;
    localparam logic [15:0] CTRL_HALT = ctrl_word(1'b0, 1'b0, 1'b0, 1'b1) & CTRL_MASK;

    tmr_state_t  state_q, state_d;
    logic [31:0] period_q, period_nxt;
    logic        pend_q;
    logic        running_q;
    logic        frame_tick_q;
    logic [15:0] tick_q;

    logic        req_vld, req_wr;
    logic [2:0]  req_addr;
    logic [15:0] req_dat;

    always_comb begin
        state_d    = state_q;
        req_vld    = 1'b0;
        req_wr     = 1'b0;
        req_addr   = TMR_ADDR_STATUS;
        req_dat    = 16'd0;
        period_nxt = period_load ? period_in : period_q;

        case (state_q)
            ST_IDLE:    if (enable) state_d = ST_WR_PL;
            ST_WR_PL:   state_d = ST_WR_PH;
            ST_WR_PH:   state_d = ST_WR_CTRL;
            ST_WR_CTRL: state_d = ST_RUN;
            ST_RUN: begin
                if (!enable)                    state_d = ST_STOP;
                else if (pend_q || period_load) state_d = ST_WR_PL;
`ifdef TIMER_POLL_EN
                else                            state_d = ST_POLL_RD;
`else
                else if (avm.timer_irq)         state_d = ST_CLR;
`endif
            end
            ST_CLR:     state_d = ST_RUN;
            ST_STOP:    state_d = ST_IDLE;
`ifdef TIMER_POLL_EN
            ST_POLL_RD:  state_d = ST_POLL_CHK;
            ST_POLL_CHK: state_d = avm.avm_readdata[STAT_TO] ? ST_CLR : ST_RUN;
`endif
            default:    state_d = ST_IDLE;
        endcase

        // Access states last one cycle, so the request is issued on entry and lands on the
        // bus while the FSM sits in that state.
        case (state_d)
            ST_WR_PL:   begin req_vld = 1'b1; req_wr = 1'b1; req_addr = TMR_ADDR_PERIOD_L; req_dat = period_nxt[15:0]; end
            ST_WR_PH:   begin req_vld = 1'b1; req_wr = 1'b1; req_addr = TMR_ADDR_PERIOD_H; req_dat = period_nxt[31:16]; end
            ST_WR_CTRL: begin req_vld = 1'b1; req_wr = 1'b1; req_addr = TMR_ADDR_CONTROL;  req_dat = CTRL_GO; end
            ST_CLR:     begin req_vld = 1'b1; req_wr = 1'b1; req_addr = TMR_ADDR_STATUS;   req_dat = 16'd0; end
            ST_STOP:    begin req_vld = 1'b1; req_wr = 1'b1; req_addr = TMR_ADDR_CONTROL;  req_dat = CTRL_HALT; end
            ST_POLL_RD: begin req_vld = 1'b1; req_wr = 1'b0; req_addr = TMR_ADDR_STATUS; end
            default:    ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            period_q     <= DEFAULT_PERIOD;
            pend_q       <= 1'b0;
            running_q    <= 1'b0;
            frame_tick_q <= 1'b0;
            tick_q       <= TICK_PRESET;
        end else begin
            state_q <= state_d;
            if (period_load) period_q <= period_in;

            // A reload seen mid-sequence is replayed from RUN; any period write sequence
            // (or a stop) already carries the newest value.
            if (period_load && state_q != ST_IDLE && state_q != ST_RUN)
                pend_q <= 1'b1;
            else if (state_d == ST_WR_PL || state_d == ST_STOP)
                pend_q <= 1'b0;

            if (state_q == ST_WR_CTRL)   running_q <= 1'b1;
            else if (state_q == ST_STOP) running_q <= 1'b0;

            frame_tick_q <= (state_d == ST_CLR);
            if (state_d == ST_CLR) tick_q <= tick_q + 16'd1;
        end
    end

    nes_avm_write_port u_port (
        .clk            (clk),
        .reset          (reset),
        .req_vld        (req_vld),
        .req_wr         (req_wr),
        .req_addr       (req_addr),
        .req_dat        (req_dat),
        .avm_address    (avm.avm_address),
        .avm_chipselect (avm.avm_chipselect),
        .avm_write_n    (avm.avm_write_n),
        .avm_writedata  (avm.avm_writedata)
    );

`ifdef TIMER_POLL_EN
    logic unused_irq;
    assign unused_irq = avm.timer_irq;
`else
    logic unused_rd;
    assign unused_rd = ^avm.avm_readdata;
`endif

    assign frame_tick = frame_tick_q;
    assign tick_count = tick_q;
    assign running    = running_q;
    assign busy       = !(state_q == ST_IDLE || state_q == ST_RUN);
endmodule

// File: tb/tb_nes_timer_sequencer.sv
// Directed bench for nes_timer_sequencer against a behavioural interval-timer slave.
// tick_count starts from a preset near 0xFFFF so the wrap is reached in a few timeouts.
module tb_nes_timer_sequencer;
    import nes_timer_pkg::*;

    logic        clk = 1'b0;
    logic        reset, enable, period_load;
    logic [31:0] period_in;
    logic        frame_tick, running, busy;
    logic [15:0] tick_count;
    int          total = 0;
    int          bad   = 0;
    int          w     = 0;
    logic [31:0] dp    = 32'd833332;
`ifdef TIMER_POLL_EN
    logic [15:0] ctrl_exp = 16'h0006;
`else
    logic [15:0] ctrl_exp = 16'h0007;
`endif

    always #5 clk = ~clk;

    nes_timer_sequencer_if bus ();

    nes_timer_sequencer #(.TICK_PRESET(16'hFFFC)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .period_in   (period_in),
        .period_load (period_load),
        .avm         (bus),
        .frame_tick  (frame_tick),
        .tick_count  (tick_count),
        .running     (running),
        .busy        (busy)
    );

    // Behavioural timer slave: counts period+1 clocks per timeout, period writes stop it.
    logic [31:0] m_per, m_cnt;
    logic        m_run, m_to, m_ito;
    int          m_reads;
    always @(posedge clk) begin
        if (reset) begin
            m_per <= 0; m_cnt <= 0; m_run <= 0; m_to <= 0; m_ito <= 0; m_reads <= 0;
            bus.avm_readdata <= 16'h0;
        end else begin
            if (m_run) begin
                if (m_cnt == 0) begin m_to <= 1'b1; m_cnt <= m_per; end
                else m_cnt <= m_cnt - 1;
            end
            bus.avm_readdata <= 16'h0;
            if (bus.avm_chipselect && bus.avm_write_n) begin
                m_reads <= m_reads + 1;
`ifdef TIMER_POLL_EN
                bus.avm_readdata <= (m_reads == 2) ? 16'h0001 : 16'h0000;
`else
                bus.avm_readdata <= {14'b0, m_run, m_to};
`endif
            end
            if (bus.avm_chipselect && !bus.avm_write_n) begin
                case (bus.avm_address)
                    TMR_ADDR_STATUS:   m_to <= 1'b0;
                    TMR_ADDR_CONTROL: begin
                        m_ito <= bus.avm_writedata[0];
                        if (bus.avm_writedata[3]) m_run <= 1'b0;
                        else if (bus.avm_writedata[2]) begin m_run <= 1'b1; m_cnt <= m_per; end
                    end
                    TMR_ADDR_PERIOD_L: begin m_per[15:0]  <= bus.avm_writedata; m_run <= 1'b0; end
                    TMR_ADDR_PERIOD_H: begin m_per[31:16] <= bus.avm_writedata; m_run <= 1'b0; end
                    default: ;
                endcase
            end
        end
    end
    assign bus.timer_irq = m_to & m_ito;

    function automatic logic [31:0] bw();
        return {11'b0, bus.avm_chipselect, bus.avm_write_n, bus.avm_address, bus.avm_writedata};
    endfunction
    function automatic logic [31:0] wr(input logic [2:0] a, input logic [15:0] d);
        return {11'b0, 1'b1, 1'b0, a, d};
    endfunction
    function automatic logic [31:0] idle();
        return {11'b0, 1'b0, 1'b1, 3'b0, 16'h0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_tick(input string tag, input int lim, output int waited);
        waited = 0;
        while (frame_tick !== 1'b1 && waited < lim) begin
            step();
            waited++;
        end
        chk(tag, {31'b0, frame_tick}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; enable = 1'b0; period_load = 1'b0; period_in = 32'd0;
        repeat (3) step();
        chk("rst_bus",  bw(), idle());
        chk("rst_tick", {31'b0, frame_tick}, 32'd0);
        chk("rst_cnt",  {16'b0, tick_count}, 32'h0000_FFFC);
        chk("rst_run",  {31'b0, running}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        reset = 1'b0;
        step();
        chk("idle_bus", bw(), idle());

        // Start with the default period
        enable = 1'b1;
        step(); chk("t1_pl", bw(), wr(3'd2, dp[15:0])); chk("t1_busy", {31'b0, busy}, 32'd1);
        step(); chk("t1_ph", bw(), wr(3'd3, dp[31:16]));
        step(); chk("t1_ctrl", bw(), wr(3'd1, ctrl_exp));
        step(); chk("t1_running", {31'b0, running}, 32'd1); chk("t1_runbus", bw(), idle());
        chk("t1_rbusy", {31'b0, busy}, 32'd0);

`ifdef TIMER_POLL_EN
        step(); chk("p_rd", bw(), {11'b0, 1'b1, 1'b1, 3'd0, 16'h0});
        begin
            int n_rd;
            n_rd = 0; w = 0;
            while (frame_tick !== 1'b1 && w < 20) begin
                if (bus.avm_chipselect === 1'b1 && bus.avm_write_n === 1'b1) n_rd++;
                step(); w++;
            end
            chk("p_tick", {31'b0, frame_tick}, 32'd1);
            chk("p_reads", n_rd, 32'd3);
            chk("p_clr", bw(), wr(3'd0, 16'h0));
            chk("p_cnt", {16'b0, tick_count}, 32'h0000_FFFD);
        end
`else
        // Reprogram to period 4 while running
        period_in = 32'd4; period_load = 1'b1;
        step(); period_load = 1'b0; chk("t2_pl", bw(), wr(3'd2, 16'h0004));
        step(); chk("t2_ph", bw(), wr(3'd3, 16'h0000));
        step(); chk("t2_ctrl", bw(), wr(3'd1, 16'h0007));
        step();
        wait_tick("t2_first", 20, w);
        chk("t2_clr", bw(), wr(3'd0, 16'h0));
        chk("t2_cnt", {16'b0, tick_count}, 32'h0000_FFFD);
        step(); chk("t2_pulse", {31'b0, frame_tick}, 32'd0);
        wait_tick("t2_next", 20, w);
        chk("t2_gap", w + 1, 32'd5);
        chk("t2_cnt2", {16'b0, tick_count}, 32'h0000_FFFE);
        for (int i = 0; i < 2; i++) begin
            step();
            wait_tick("t3_tick", 20, w);
        end
        chk("t3_wrap", {16'b0, tick_count}, 32'h0000_0000);

        // Reprogram to 0x1000 from RUN
        step();
        period_in = 32'h0000_1000; period_load = 1'b1;
        step(); period_load = 1'b0; chk("t4_pl", bw(), wr(3'd2, 16'h1000));
        step(); chk("t4_ph", bw(), wr(3'd3, 16'h0000));
        step(); chk("t4_ctrl", bw(), wr(3'd1, 16'h0007));
        step();
        wait_tick("t4_first", 5000, w);
        step();
        wait_tick("t4_next", 5000, w);
        chk("t4_gap", w + 1, 32'd4097);
        chk("t4_cnt", {16'b0, tick_count}, 32'd2);

        // enable drops in the same cycle the irq is seen
        step();
        w = 0;
        while (bus.timer_irq !== 1'b1 && w < 5000) begin step(); w++; end
        chk("t5_irq", {31'b0, bus.timer_irq}, 32'd1);
        enable = 1'b0;
        step(); chk("t5_stop", bw(), wr(3'd1, 16'h0008));
        chk("t5_notick", {31'b0, frame_tick}, 32'd0);
        chk("t5_busy", {31'b0, busy}, 32'd1);
        step(); chk("t5_running", {31'b0, running}, 32'd0);
        chk("t5_idle", bw(), idle());
        chk("t5_cnt", {16'b0, tick_count}, 32'd2);

        // Reload during the period writes is replayed once RUN is reached
        enable = 1'b1;
        step(); chk("t6_pl", bw(), wr(3'd2, 16'h1000));
        period_in = 32'd6; period_load = 1'b1;
        step(); period_load = 1'b0; chk("t6_ph", bw(), wr(3'd3, 16'h0000));
        step(); chk("t6_ctrl", bw(), wr(3'd1, 16'h0007));
        step(); chk("t6_run", bw(), idle());
        step(); chk("t6_pl2", bw(), wr(3'd2, 16'h0006));
        step(); chk("t6_ph2", bw(), wr(3'd3, 16'h0000));
        step(); chk("t6_ctrl2", bw(), wr(3'd1, 16'h0007));
        step();
        wait_tick("t6_first", 50, w);
        step();
        wait_tick("t6_next", 50, w);
        chk("t6_gap", w + 1, 32'd7);

        // Reset in the middle of a write sequence
        step();
        period_in = 32'd5; period_load = 1'b1;
        step(); period_load = 1'b0; chk("t7_pl", bw(), wr(3'd2, 16'h0005));
        reset = 1'b1;
        step(); chk("t7_bus", bw(), idle());
        chk("t7_busy", {31'b0, busy}, 32'd0);
        chk("t7_running", {31'b0, running}, 32'd0);
        chk("t7_cnt", {16'b0, tick_count}, 32'h0000_FFFC);
        reset = 1'b0;
`endif
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
